// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath/instruction-register side.
interface multicycle_control_unit_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       Branch;
    logic       BranchNe;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, funct, mem_ready,
        output PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               Branch, BranchNe, ALUSrcB, PCSrc, ALUControl, instr_done, illegal_op, state
    );

    modport slave (
        output op, funct, mem_ready,
        input  PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               Branch, BranchNe, ALUSrcB, PCSrc, ALUControl, instr_done, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore-style multicycle MIPS controller: sequences one instruction per 3-5 cycles
// plus memory wait states, with optional addi/bne decode and an illegal-op trap.
module multicycle_control_unit #(
    parameter bit ADDI_EN       = 1'b1,
    parameter bit BNE_EN        = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input logic                         clk,
    input logic                         rst_n,
    multicycle_control_unit_if.master   bus
);
    typedef enum logic [3:0] {
        StFetch    = 4'd0,  StDecode   = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
        StMemWb    = 4'd4,  StMemWr    = 4'd5,  StExecute = 4'd6, StAluWb  = 4'd7,
        StBranch   = 4'd8,  StAddiExec = 4'd9,  StAddiWb = 4'd10, StJump   = 4'd11,
        StTrap     = 4'd15
    } state_e;

    localparam logic [5:0] OpLw = 6'b100011, OpSw  = 6'b101011, OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpAddi = 6'b001000;
    localparam logic [5:0] OpJ = 6'b000010;

    state_e     state_q, state_d;
    logic       mem_rdy, funct_ok;
    logic       pc_write, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, branch, branch_ne, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [2:0] alu_ctrl;

    assign mem_rdy  = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    assign funct_ok = bus.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFetch;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            StFetch: begin
                alu_src_b = 2'b01;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
                if (mem_rdy) state_d = StDecode;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (bus.op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = funct_ok ? StExecute : StTrap;
                    OpBeq:      state_d = StBranch;
                    OpBne:      state_d = BNE_EN ? StBranch : StTrap;
                    OpAddi:     state_d = ADDI_EN ? StAddiExec : StTrap;
                    OpJ:        state_d = StJump;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord = 1'b1;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_rdy;
                if (mem_rdy) state_d = StFetch;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                instr_done = 1'b1;
                branch     = (bus.op == OpBeq);
                branch_ne  = (bus.op == OpBne);
                state_d    = StFetch;
            end
            StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                illegal_op = 1'b1;
                state_d    = StTrap;
            end
            default: state_d = StFetch;
        endcase
    end

    // ALUControl follows ALUOp in every state, so states without an ALU role show add.
    always_comb begin
        alu_ctrl = 3'b010;
        case (alu_op)
            2'b01: alu_ctrl = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100010: alu_ctrl = 3'b110;
                    6'b100100: alu_ctrl = 3'b000;
                    6'b100101: alu_ctrl = 3'b001;
                    6'b101010: alu_ctrl = 3'b111;
                    default:   alu_ctrl = 3'b010;
                endcase
            end
            default: alu_ctrl = 3'b010;
        endcase
    end

    // Outputs are gated by rst_n so a reset mid-access drops enables without a clock edge.
    assign bus.PCWrite    = rst_n & pc_write;
    assign bus.IorD       = rst_n & iord;
    assign bus.MemWrite   = rst_n & mem_write;
    assign bus.IRWrite    = rst_n & ir_write;
    assign bus.RegDst     = rst_n & reg_dst;
    assign bus.MemtoReg   = rst_n & mem_to_reg;
    assign bus.RegWrite   = rst_n & reg_write;
    assign bus.ALUSrcA    = rst_n & alu_src_a;
    assign bus.Branch     = rst_n & branch;
    assign bus.BranchNe   = rst_n & branch_ne;
    assign bus.instr_done = rst_n & instr_done;
    assign bus.illegal_op = rst_n & illegal_op;
    assign bus.ALUSrcB    = rst_n ? alu_src_b : 2'b00;
    assign bus.PCSrc      = rst_n ? pc_src : 2'b00;
    assign bus.ALUControl = rst_n ? alu_ctrl : 3'b000;
    assign bus.state      = state_q;
endmodule
